// File: rtl/gate_link_pkg.sv
// Shared types and helpers for the per-gate link agent.
package gate_link_pkg;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    typedef enum logic {
        RX_FILL,
        RX_FULL
    } rx_state_e;

    function automatic int cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/gate_link_deser.sv
// Receive side of the gate link: assembles LSB-first bits into a word and
// hands it to local logic on rx_pull.
module gate_link_deser
    import gate_link_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sync,
    input  logic                  i_rx_pull,
    input  logic                  i_ser_data,
    input  logic                  i_ser_valid,
    output logic                  o_rx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_ovf
);

    localparam int CW = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ready_d = ready_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        if (i_sync) begin
            state_d = RX_FILL;
            cnt_d   = '0;
            ready_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                RX_FILL: begin
                    if (i_ser_valid) begin
                        // Bit lands at its final position, so bit 0 is the first one received.
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (cnt_q == CW'(i)) shift_d[i] = i_ser_data;
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_d = RX_FULL;
                            ready_d = 1'b1;
                        end
                    end
                end
                RX_FULL: begin
                    if (i_rx_pull) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ready_d = 1'b0;
                        state_d = RX_FILL;
                        cnt_d   = '0;
                        // A bit arriving with the pull starts the next word.
                        if (i_ser_valid) begin
                            shift_d[0] = i_ser_data;
                            cnt_d      = CW'(1);
                        end
                    end else if (i_ser_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = RX_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RX_FILL;
            cnt_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_rx_ready = ready_q;
    assign o_rx_data  = data_q;
    assign o_rx_valid = valid_q;
    assign o_rx_ovf   = ovf_q;

endmodule

// File: rtl/gate_link_agent.sv
// Per-gate link responder: serialises a local word on tx_start and delivers
// the assembled incoming word on rx_pull.
module gate_link_agent
    import gate_link_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sync,
    input  logic                  i_tx_start,
    input  logic                  i_rx_pull,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_ser_data,
    input  logic                  i_ser_valid,
    output logic                  o_ser_data,
    output logic                  o_ser_valid,
    output logic                  o_tx_ready,
    output logic                  o_rx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_tx_err,
    output logic                  o_rx_ovf
);

    localparam int CW = cnt_w(DATA_WIDTH);

    tx_state_e             tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  tx_err_q, tx_err_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        ser_data_d  = ser_data_q;
        ser_valid_d = ser_valid_q;
        tx_ready_d  = tx_ready_q;
        tx_err_d    = tx_err_q;
        if (i_sync) begin
            tx_state_d  = TX_IDLE;
            ser_data_d  = 1'b0;
            ser_valid_d = 1'b0;
            tx_ready_d  = 1'b1;
            tx_err_d    = 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (i_tx_start) begin
                        // Bit 0 goes straight to the output flop; the rest waits in the shifter.
                        ser_data_d  = i_tx_data[0];
                        ser_valid_d = 1'b1;
                        tx_ready_d  = 1'b0;
                        tx_shift_d  = i_tx_data >> 1;
                        tx_cnt_d    = CW'(DATA_WIDTH);
                        tx_state_d  = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (i_tx_start) tx_err_d = 1'b1;
                    if (tx_cnt_q == CW'(1)) begin
                        ser_data_d  = 1'b0;
                        ser_valid_d = 1'b0;
                        tx_ready_d  = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end else begin
                        ser_data_d = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_cnt_d   = tx_cnt_q - CW'(1);
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_err_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            tx_ready_q  <= tx_ready_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign o_ser_data  = ser_data_q;
    assign o_ser_valid = ser_valid_q;
    assign o_tx_ready  = tx_ready_q;
    assign o_tx_err    = tx_err_q;

    gate_link_deser #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sync      (i_sync),
        .i_rx_pull   (i_rx_pull),
        .i_ser_data  (i_ser_data),
        .i_ser_valid (i_ser_valid),
        .o_rx_ready  (o_rx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_rx_ovf    (o_rx_ovf)
    );

endmodule

// File: tb/tb_gate_link_agent.sv
// Self-checking bench for gate_link_agent: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_gate_link_agent;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          i_rst, i_sync, i_tx_start, i_rx_pull, i_ser_data, i_ser_valid;
    logic [DW-1:0] i_tx_data;
    logic          o_ser_data, o_ser_valid, o_tx_ready, o_rx_ready, o_rx_valid, o_tx_err, o_rx_ovf;
    logic [DW-1:0] o_rx_data;

    always #5 clk = ~clk;

    gate_link_agent #(.DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_sync      (i_sync),
        .i_tx_start  (i_tx_start),
        .i_rx_pull   (i_rx_pull),
        .i_tx_data   (i_tx_data),
        .i_ser_data  (i_ser_data),
        .i_ser_valid (i_ser_valid),
        .o_ser_data  (o_ser_data),
        .o_ser_valid (o_ser_valid),
        .o_tx_ready  (o_tx_ready),
        .o_rx_ready  (o_rx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_tx_err    (o_tx_err),
        .o_rx_ovf    (o_rx_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: TX is "which bit index is on the wire", RX is a queue of received bits.
    int            m_idx;
    logic [DW-1:0] m_word;
    logic          m_err, m_ovf, m_rxv;
    logic [DW-1:0] m_rxd;
    bit            m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_idx  = -1;
        m_word = '0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_rxv  = 1'b0;
        m_rxd  = '0;
        m_q.delete();
    endfunction

    function automatic void m_edge();
        logic [DW-1:0] w;
        m_rxv = 1'b0;
        if (i_sync) begin
            m_idx = -1;
            m_err = 1'b0;
            m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        if (m_idx < 0) begin
            if (i_tx_start) begin
                m_word = i_tx_data;
                m_idx  = 0;
            end
        end else begin
            if (i_tx_start) m_err = 1'b1;
            m_idx = (m_idx == DW - 1) ? -1 : m_idx + 1;
        end
        if (m_q.size() == DW) begin
            if (i_rx_pull) begin
                w = '0;
                foreach (m_q[k]) w[k] = m_q[k];
                m_rxd = w;
                m_rxv = 1'b1;
                m_q.delete();
                if (i_ser_valid) m_q.push_back(i_ser_data);
            end else if (i_ser_valid) begin
                m_ovf = 1'b1;
            end
        end else if (i_ser_valid) begin
            m_q.push_back(i_ser_data);
        end
    endfunction

    task automatic check_outputs();
        logic exp_bit;
        exp_bit = (m_idx >= 0) ? m_word[m_idx] : 1'b0;
        check("ser_valid", 32'(o_ser_valid), 32'(m_idx >= 0));
        check("ser_data",  32'(o_ser_data),  32'(exp_bit));
        check("tx_ready",  32'(o_tx_ready),  32'(m_idx < 0));
        check("rx_ready",  32'(o_rx_ready),  32'(m_q.size() == DW));
        check("rx_data",   32'(o_rx_data),   32'(m_rxd));
        check("rx_valid",  32'(o_rx_valid),  32'(m_rxv));
        check("tx_err",    32'(o_tx_err),    32'(m_err));
        check("rx_ovf",    32'(o_rx_ovf),    32'(m_ovf));
    endtask

    task automatic cyc(input logic s, input logic st, input logic p, input logic v,
                       input logic d, input logic [DW-1:0] x);
        i_sync      = s;
        i_tx_start  = st;
        i_rx_pull   = p;
        i_ser_valid = v;
        i_ser_data  = d;
        i_tx_data   = x;
        @(posedge clk);
        m_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, w[i], '0);
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] word;
        int            low_cnt;

        i_rst = 1'b1; i_sync = 1'b0; i_tx_start = 1'b0; i_rx_pull = 1'b0;
        i_ser_data = 1'b0; i_ser_valid = 1'b0; i_tx_data = '0;
        m_reset();
        #1;
        $display("[TB] reset state");
        check_outputs();
        #12 i_rst = 1'b0;

        // Transmit 0xA5 and gather the wire bits.
        $display("[TB] tx 0xA5");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        got = '0; low_cnt = 0;
        for (int i = 0; i < DW; i++) begin
            got[i] = o_ser_data;
            if (!o_tx_ready) low_cnt++;
            idle();
        end
        check("a5_stream", 32'(got), 32'h0000_00A5);
        check("a5_ready_low_cycles", 32'(low_cnt), 32'd8);
        check("a5_ready_back", 32'(o_tx_ready), 32'd1);

        // Receive 0x3C and pull it.
        $display("[TB] rx 0x3C");
        send_word(8'h3C);
        check("3c_ready", 32'(o_rx_ready), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("3c_valid", 32'(o_rx_valid), 32'd1);
        check("3c_data", 32'(o_rx_data), 32'h0000_003C);
        check("3c_ready_clear", 32'(o_rx_ready), 32'd0);
        idle();

        // Overflow on a ninth bit, then sync clears it.
        $display("[TB] rx overflow and sync");
        send_word(8'h5A);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("ovf_set", 32'(o_rx_ovf), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("ovf_sync_clear", 32'(o_rx_ovf), 32'd0);
        check("ready_sync_clear", 32'(o_rx_ready), 32'd0);
        check("rx_data_retained", 32'(o_rx_data), 32'h0000_003C);

        // Pull with a coincident bit: that bit starts the next word.
        $display("[TB] pull with coincident bit");
        send_word(8'h81);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
        check("coinc_no_ovf", 32'(o_rx_ovf), 32'd0);
        check("coinc_data", 32'(o_rx_data), 32'h0000_0081);
        for (int i = 1; i < DW; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("coinc_full", 32'(o_rx_ready), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("coinc_next_word", 32'(o_rx_data), 32'h0000_0001);

        // tx_start mid-frame: error flagged, original data continues.
        $display("[TB] tx_start while busy");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
        got = '0;
        got[0] = o_ser_data;
        for (int i = 1; i < DW; i++) begin
            cyc(1'b0, (i == 3), 1'b0, 1'b0, 1'b0, 8'h00);
            got[i] = o_ser_data;
        end
        check("busy_err", 32'(o_tx_err), 32'd1);
        check("busy_stream", 32'(got), 32'h0000_00C3);
        idle();
        idle();

        // Asynchronous reset mid-frame.
        $display("[TB] reset mid-frame");
        send_word(8'hF0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) idle();
        i_rst = 1'b1;
        #1;
        m_reset();
        check_outputs();
        check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
        check("rst_ser_valid", 32'(o_ser_valid), 32'd0);
        #1 i_rst = 1'b0;

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            word = DW'($urandom);
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                1'($urandom), word);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
